// File: rtl/clock_pkg.sv
// Shared limits and divider helpers for the hour/minute/second timekeeper.
// Pure constants and elaboration-time functions; no logic, no latency.
package clock_pkg;

   localparam int SEC_MAX       = 59;
   localparam int MIN_MAX       = 59;
   localparam int HOUR_MAX_24   = 23;
   localparam int HOUR_12_RESET = 12;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   function automatic int calc_presc_w(input int div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/timekeeper_hms_if.sv
// Control/alarm inputs and time outputs of timekeeper_hms, bundled as one port.
// Plain wires; no latency and no backpressure.
interface timekeeper_hms_if #(
   parameter int W = 7
) ();

   logic         run;
   logic         set_en;
   logic [W-1:0] set_sec;
   logic [W-1:0] set_min;
   logic [W-1:0] set_hour;
   logic         set_pm;
   logic         inc_min;
   logic         inc_hour;
   logic         alarm_en;
   logic [W-1:0] alarm_min;
   logic [W-1:0] alarm_hour;
   logic         alarm_pm;

   logic [W-1:0] second;
   logic [W-1:0] minute;
   logic [W-1:0] hour;
   logic         pm;
   logic         sec_tick;
   logic         set_err;
   logic         alarm_hit;

   modport master (
      output run, set_en, set_sec, set_min, set_hour, set_pm,
      output inc_min, inc_hour, alarm_en, alarm_min, alarm_hour, alarm_pm,
      input  second, minute, hour, pm, sec_tick, set_err, alarm_hit
   );

   modport slave (
      input  run, set_en, set_sec, set_min, set_hour, set_pm,
      input  inc_min, inc_hour, alarm_en, alarm_min, alarm_hour, alarm_pm,
      output second, minute, hour, pm, sec_tick, set_err, alarm_hit
   );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous load; load beats inc. q is registered, one cycle
// after inc/load. carry is combinational (inc while at MAX). Never stalls.
module wrap_counter #(
   parameter int MAX = 59,
   parameter int W   = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] q,
   output logic         carry
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   assign carry = inc && (q_q == W'(MAX));

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (inc) begin
         q_d = carry ? '0 : q_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/timekeeper_hms.sv
// Time-of-day counter (12h/24h) with prescaler, load, per-field increment and alarm.
// Outputs registered, update one cycle after the causing input; never stalls its inputs.
module timekeeper_hms
   import clock_pkg::*;
#(
   parameter int CLK_HZ   = 50_000_000,
   parameter int TICK_HZ  = 1,
   parameter int MODE_12H = 0,
   parameter int W        = 7
) (
   input logic             clk,
   input logic             rst,
   timekeeper_hms_if.slave bus
);

   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int PW  = calc_presc_w(DIV);
   localparam logic [W-1:0] HOUR_RST = (MODE_12H != 0) ? W'(HOUR_12_RESET) : '0;

   logic [PW-1:0] presc_q, presc_d;
   logic          pend_q, pend_d;
   logic [W-1:0]  hour_q, hour_d;
   logic          pm_q, pm_d;
   logic          sec_tick_q, sec_tick_d;
   logic          set_err_q, set_err_d;
   logic          alarm_hit_q, alarm_hit_d;

   logic [W-1:0]  second;
   logic [W-1:0]  minute;
   logic          tick;
   logic          hour_ok;
   logic          set_ok;
   logic          inc_min_eff;
   logic          inc_hour_eff;
   logic          inc_any;
   logic          adv;
   logic          sec_carry;
   logic          min_carry;
   logic          hour_step;

   always_comb begin
      hour_ok = 1'b0;
      if (MODE_12H != 0) begin
         hour_ok = (bus.set_hour >= W'(1)) && (bus.set_hour <= W'(HOUR_12_RESET));
      end else begin
         hour_ok = (bus.set_hour <= W'(HOUR_MAX_24));
      end
   end

   assign tick         = bus.run && (presc_q == PW'(DIV - 1));
   assign set_ok       = bus.set_en && hour_ok &&
                         (bus.set_sec <= W'(SEC_MAX)) && (bus.set_min <= W'(MIN_MAX));
   assign inc_min_eff  = bus.inc_min && !set_ok;
   assign inc_hour_eff = bus.inc_hour && !set_ok;
   assign inc_any      = inc_min_eff || inc_hour_eff;
   // A tick that collides with a button increment is deferred by one cycle, never dropped.
   assign adv          = !set_ok && !inc_any && (pend_q || tick);
   assign hour_step    = inc_hour_eff || (min_carry && !inc_min_eff);

   wrap_counter #(.MAX(SEC_MAX), .W(W)) u_sec (
      .clk      (clk),
      .rst      (rst),
      .inc      (adv),
      .load     (set_ok),
      .load_val (bus.set_sec),
      .q        (second),
      .carry    (sec_carry)
   );

   wrap_counter #(.MAX(MIN_MAX), .W(W)) u_min (
      .clk      (clk),
      .rst      (rst),
      .inc      (sec_carry || inc_min_eff),
      .load     (set_ok),
      .load_val (bus.set_min),
      .q        (minute),
      .carry    (min_carry)
   );

   always_comb begin
      presc_d     = presc_q;
      pend_d      = pend_q;
      hour_d      = hour_q;
      pm_d        = pm_q;
      sec_tick_d  = adv;
      set_err_d   = bus.set_en && !set_ok;
      alarm_hit_d = bus.alarm_en && sec_tick_q && (second == '0) &&
                    (minute == bus.alarm_min) && (hour_q == bus.alarm_hour) &&
                    ((MODE_12H == 0) || (pm_q == bus.alarm_pm));

      if (set_ok) begin
         presc_d = '0;
         pend_d  = 1'b0;
      end else begin
         if (bus.run) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
         end
         pend_d = inc_any ? (pend_q || tick) : (pend_q && tick);
      end

      if (set_ok) begin
         hour_d = bus.set_hour;
         pm_d   = (MODE_12H != 0) ? bus.set_pm : 1'b0;
      end else if (hour_step) begin
         if (MODE_12H != 0) begin
            // 12h dial: 11 -> 12 flips am/pm, 12 -> 1 keeps it.
            if (hour_q == W'(HOUR_12_RESET - 1)) begin
               hour_d = W'(HOUR_12_RESET);
               pm_d   = ~pm_q;
            end else if (hour_q == W'(HOUR_12_RESET)) begin
               hour_d = W'(1);
            end else begin
               hour_d = hour_q + W'(1);
            end
         end else begin
            hour_d = (hour_q == W'(HOUR_MAX_24)) ? '0 : hour_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         pend_q      <= 1'b0;
         hour_q      <= HOUR_RST;
         pm_q        <= 1'b0;
         sec_tick_q  <= 1'b0;
         set_err_q   <= 1'b0;
         alarm_hit_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         pend_q      <= pend_d;
         hour_q      <= hour_d;
         pm_q        <= pm_d;
         sec_tick_q  <= sec_tick_d;
         set_err_q   <= set_err_d;
         alarm_hit_q <= alarm_hit_d;
      end
   end

   assign bus.second    = second;
   assign bus.minute    = minute;
   assign bus.hour      = hour_q;
   assign bus.pm        = pm_q;
   assign bus.sec_tick  = sec_tick_q;
   assign bus.set_err   = set_err_q;
   assign bus.alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_timekeeper_hms.sv
// Drives a 24h and a 12h timekeeper with identical stimulus and scoreboards both
// against a seconds-of-day reference model.
module tb_timekeeper_hms;

   localparam int W       = 7;
   localparam int CLK_HZ  = 4;
   localparam int TICK_HZ = 1;
   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int DAY     = 24 * 3600;

   typedef struct {
      bit rst, run, set_en, spm, imin, ihour, aen, apm;
      int ss, sm, sh, am, ah;
   } stim_t;

   typedef struct {
      int sec, min, hour;
      bit pm, st, err, ah;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   timekeeper_hms_if #(.W(W)) bus0 ();
   timekeeper_hms_if #(.W(W)) bus1 ();

   timekeeper_hms #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MODE_12H(0), .W(W)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   timekeeper_hms #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MODE_12H(1), .W(W)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   stim_t s;
   exp_t  q0[$];
   exp_t  q1[$];
   int    n_assert = 0;
   int    n_fail   = 0;

   // Reference state per mode: time as seconds since midnight plus prescaler phase.
   int    t_m[2];
   int    cnt_m[2];
   bit    pend_m[2];
   bit    st_m[2];
   bit    err_m[2];
   bit    ah_m[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic display_hour(input int m, input int t, output int dh, output bit dpm);
      int h24;
      h24 = t / 3600;
      if (m == 0) begin
         dh  = h24;
         dpm = 1'b0;
      end else begin
         dpm = (h24 >= 12);
         dh  = (h24 % 12 == 0) ? 12 : h24 % 12;
      end
   endtask

   task automatic model_step(input int m);
      int   h, mi, sc, dh;
      bit   dpm, valid, setok, tick, alarm;
      exp_t e;
      if (s.rst) begin
         t_m[m] = 0; cnt_m[m] = 0; pend_m[m] = 0;
         st_m[m] = 0; err_m[m] = 0; ah_m[m] = 0;
      end else begin
         display_hour(m, t_m[m], dh, dpm);
         alarm = s.aen && st_m[m] && (t_m[m] % 60 == 0) && ((t_m[m] / 60) % 60 == s.am) &&
                 (dh == s.ah) && (m == 0 || dpm == s.apm);
         if (m == 0) valid = (s.ss < 60) && (s.sm < 60) && (s.sh <= 23);
         else        valid = (s.ss < 60) && (s.sm < 60) && (s.sh >= 1) && (s.sh <= 12);
         setok    = s.set_en && valid;
         tick     = s.run && (cnt_m[m] == DIV - 1);
         err_m[m] = s.set_en && !valid;
         st_m[m]  = 0;
         if (setok) begin
            h        = (m == 0) ? s.sh : (s.sh % 12) + (s.spm ? 12 : 0);
            t_m[m]   = h * 3600 + s.sm * 60 + s.ss;
            cnt_m[m] = 0;
            pend_m[m] = 0;
         end else begin
            if (s.run) cnt_m[m] = (cnt_m[m] + 1) % DIV;
            if (s.imin || s.ihour) begin
               h  = t_m[m] / 3600;
               mi = (t_m[m] / 60) % 60;
               sc = t_m[m] % 60;
               if (s.imin)  mi = (mi + 1) % 60;
               if (s.ihour) h  = (h + 1) % 24;
               t_m[m]    = h * 3600 + mi * 60 + sc;
               pend_m[m] = pend_m[m] || tick;
            end else if (pend_m[m] || tick) begin
               t_m[m]    = (t_m[m] + 1) % DAY;
               st_m[m]   = 1;
               pend_m[m] = pend_m[m] && tick;
            end
         end
         ah_m[m] = alarm;
      end
      display_hour(m, t_m[m], dh, dpm);
      e.sec  = t_m[m] % 60;
      e.min  = (t_m[m] / 60) % 60;
      e.hour = dh;
      e.pm   = dpm;
      e.st   = st_m[m];
      e.err  = err_m[m];
      e.ah   = ah_m[m];
      if (m == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic cyc();
      @(negedge clk);
      rst = s.rst;
      bus0.run = s.run;          bus1.run = s.run;
      bus0.set_en = s.set_en;    bus1.set_en = s.set_en;
      bus0.set_sec = W'(s.ss);   bus1.set_sec = W'(s.ss);
      bus0.set_min = W'(s.sm);   bus1.set_min = W'(s.sm);
      bus0.set_hour = W'(s.sh);  bus1.set_hour = W'(s.sh);
      bus0.set_pm = s.spm;       bus1.set_pm = s.spm;
      bus0.inc_min = s.imin;     bus1.inc_min = s.imin;
      bus0.inc_hour = s.ihour;   bus1.inc_hour = s.ihour;
      bus0.alarm_en = s.aen;     bus1.alarm_en = s.aen;
      bus0.alarm_min = W'(s.am); bus1.alarm_min = W'(s.am);
      bus0.alarm_hour = W'(s.ah); bus1.alarm_hour = W'(s.ah);
      bus0.alarm_pm = s.apm;     bus1.alarm_pm = s.apm;
      model_step(0);
      model_step(1);
   endtask

   task automatic set_time(input int h, input int mi, input int sc, input bit pm);
      s.set_en = 1; s.sh = h; s.sm = mi; s.ss = sc; s.spm = pm;
      cyc();
      s.set_en = 0;
   endtask

   // Advance until the 24h model's prescaler is about to tick (bounded).
   task automatic to_tick_cycle();
      for (int i = 0; i < 2 * DIV; i++) begin
         if (cnt_m[0] == DIV - 1 && s.run) break;
         cyc();
      end
   endtask

   task automatic check_out(input string tag, input exp_t e,
                            input logic [W-1:0] sec, input logic [W-1:0] mn,
                            input logic [W-1:0] hr, input logic pm, input logic st,
                            input logic er, input logic ah);
      chk({tag, " second"},    32'(sec), 32'(e.sec));
      chk({tag, " minute"},    32'(mn),  32'(e.min));
      chk({tag, " hour"},      32'(hr),  32'(e.hour));
      chk({tag, " pm"},        32'(pm),  32'(e.pm));
      chk({tag, " sec_tick"},  32'(st),  32'(e.st));
      chk({tag, " set_err"},   32'(er),  32'(e.err));
      chk({tag, " alarm_hit"}, 32'(ah),  32'(e.ah));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check_out("h24", e, bus0.second, bus0.minute, bus0.hour, bus0.pm,
                      bus0.sec_tick, bus0.set_err, bus0.alarm_hit);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check_out("h12", e, bus1.second, bus1.minute, bus1.hour, bus1.pm,
                      bus1.sec_tick, bus1.set_err, bus1.alarm_hit);
         end
      end
   end

   initial begin : stimulus
      bit prev_inc;
      s = '{default: 0};
      s.rst = 1;
      cyc();
      cyc();
      s.rst = 0;
      s.run = 1;

      // Free run through one full minute.
      repeat (240) cyc();

      // Day rollover, then the 11:59:59 am -> 12:00:00 pm boundary.
      set_time(23, 59, 58, 0);
      repeat (10) cyc();
      set_time(11, 59, 59, 0);
      repeat (6) cyc();
      set_time(11, 59, 59, 1);
      repeat (6) cyc();

      // Rejected load, then a valid load restarting the prescaler.
      set_time(10, 20, 60, 0);
      cyc();
      set_time(10, 60, 30, 0);
      set_time(10, 20, 30, 0);
      repeat (9) cyc();

      // Increment colliding with a tick; minute wrap without hour carry; both incs.
      set_time(0, 0, 4, 0);
      for (int i = 0; i < 4 * DIV; i++) begin
         if (cnt_m[0] == DIV - 1 && t_m[0] == 5) break;
         cyc();
      end
      s.imin = 1; cyc(); s.imin = 0;
      repeat (3) cyc();
      set_time(1, 59, 10, 0);
      s.imin = 1; cyc(); s.imin = 0;
      cyc();
      s.imin = 1; s.ihour = 1; cyc(); s.imin = 0; s.ihour = 0;
      set_time(11, 0, 0, 0);
      s.ihour = 1; cyc(); s.ihour = 0;
      cyc();
      s.ihour = 1; cyc(); s.ihour = 0;
      set_time(12, 30, 0, 1);
      s.ihour = 1; cyc(); s.ihour = 0;
      repeat (3) cyc();

      // Alarm: fires once via tick advance, not via direct load; pm must match in 12h.
      s.aen = 1; s.am = 30; s.ah = 7; s.apm = 0;
      set_time(7, 29, 58, 0);
      repeat (16) cyc();
      set_time(7, 30, 0, 0);
      repeat (8) cyc();
      s.apm = 1;
      set_time(7, 29, 59, 0);
      repeat (8) cyc();
      s.aen = 0;
      set_time(7, 29, 59, 0);
      repeat (8) cyc();

      // Pending tick applied while run is low.
      to_tick_cycle();
      s.imin = 1; cyc(); s.imin = 0;
      s.run = 0;
      repeat (4) cyc();
      s.run = 1;

      // Reset with a pending tick outstanding, then freeze for 100 clocks.
      repeat (9) cyc();
      to_tick_cycle();
      s.ihour = 1; cyc(); s.ihour = 0;
      s.rst = 1; cyc(); s.rst = 0;
      repeat (13) cyc();
      s.run = 0;
      repeat (100) cyc();
      s.run = 1;

      // Randomized traffic.
      prev_inc = 0;
      for (int n = 0; n < 4000; n++) begin
         s.rst = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 79) == 0) s.run = ~s.run;
         s.set_en = ($urandom_range(0, 31) == 0);
         if (s.set_en) begin
            s.ss  = $urandom_range(0, 63);
            s.sm  = $urandom_range(0, 63);
            s.sh  = $urandom_range(0, 24);
            s.spm = 1'($urandom_range(0, 1));
         end
         s.imin  = !prev_inc && ($urandom_range(0, 9) == 0);
         s.ihour = !prev_inc && ($urandom_range(0, 11) == 0);
         prev_inc = s.imin || s.ihour;
         if ($urandom_range(0, 199) == 0) begin
            s.aen = 1'($urandom_range(0, 1));
            s.am  = $urandom_range(0, 59);
            s.ah  = $urandom_range(0, 23);
            s.apm = 1'($urandom_range(0, 1));
         end
         cyc();
      end

      s.rst = 0; s.set_en = 0; s.imin = 0; s.ihour = 0;
      repeat (3) cyc();
      @(posedge clk);
      #2;
      chk("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
